// File: rtl/rim_path_checker.sv
// Path checker for the rat-in-maze solver: snoops the 8x8 maze, judges the solver's path stream.
// Optional: define RIM_CHK_REVISIT_EN to flag revisited cells (code 7) via a 64-bit visited map.
module rim_path_checker #(
  parameter int PATH_LEN = 15,
  parameter int TIMEOUT  = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] maze,
  input  logic       out_valid,
  input  logic [2:0] out_row,
  input  logic [2:0] out_col,
  output logic       chk_done,
  output logic       chk_pass,
  output logic [2:0] chk_err,
  output logic [4:0] chk_steps
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_PATH   = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;

  localparam logic [4:0] K_LEN  = PATH_LEN[4:0];
  localparam logic [9:0] TO_LIM = TIMEOUT[9:0];

  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_START = 3'd1;
  localparam logic [2:0] E_WALL  = 3'd2;
  localparam logic [2:0] E_ADJ   = 3'd3;
  localparam logic [2:0] E_END   = 3'd4;
  localparam logic [2:0] E_LEN   = 3'd5;
  localparam logic [2:0] E_TMO   = 3'd6;
`ifdef RIM_CHK_REVISIT_EN
  localparam logic [2:0] E_REV   = 3'd7;
`endif

  logic [2:0]      state_q, state_d;
  logic [7:0][7:0] maze_q, maze_d;
  logic [2:0]      row_cnt_q, row_cnt_d;
  logic [9:0]      idle_q, idle_d;
  logic [4:0]      k_q, k_d;
  logic [2:0]      err_q, err_d;
  logic [2:0]      prev_r_q, prev_r_d;
  logic [2:0]      prev_c_q, prev_c_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [2:0]      errout_q, errout_d;
  logic [4:0]      steps_q, steps_d;
`ifdef RIM_CHK_REVISIT_EN
  logic [63:0]     visited_q, visited_d;
`endif

  // Per-coordinate judgement; deltas are 4-bit signed so 7->0 is never adjacent.
  logic            cell_open;
  logic signed [3:0] dr, dc;
  logic [3:0]      adr, adc;
  logic            adj;
  logic [2:0]      code;
  logic [2:0]      fin_err;

  assign cell_open = maze_q[out_row][~out_col];
  assign dr  = $signed({1'b0, out_row}) - $signed({1'b0, prev_r_q});
  assign dc  = $signed({1'b0, out_col}) - $signed({1'b0, prev_c_q});
  assign adr = (dr < 0) ? 4'(-dr) : 4'(dr);
  assign adc = (dc < 0) ? 4'(-dc) : 4'(dc);
  assign adj = (adr + adc) == 4'd1;

  always_comb begin
    code = E_NONE;
    if (k_q == 5'd0 && (out_row != 3'd0 || out_col != 3'd0)) code = E_START;
    else if (!cell_open) code = E_WALL;
`ifdef RIM_CHK_REVISIT_EN
    else if (visited_q[{out_row, out_col}]) code = E_REV;
`endif
    else if (k_q != 5'd0 && !adj) code = E_ADJ;
    else if (k_q >= K_LEN) code = E_LEN;
  end

  // End-of-path verdict: length outranks the end-cell check.
  always_comb begin
    fin_err = err_q;
    if (err_q == E_NONE) begin
      if (k_q != K_LEN) fin_err = E_LEN;
      else if (prev_r_q != 3'd7 || prev_c_q != 3'd7) fin_err = E_END;
    end
  end

  always_comb begin
    state_d   = state_q;
    maze_d    = maze_q;
    row_cnt_d = row_cnt_q;
    idle_d    = idle_q;
    k_d       = k_q;
    err_d     = err_q;
    prev_r_d  = prev_r_q;
    prev_c_d  = prev_c_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    errout_d  = errout_q;
    steps_d   = steps_q;
`ifdef RIM_CHK_REVISIT_EN
    visited_d = visited_q;
`endif
    case (state_q)
      S_IDLE, S_REPORT: begin
        // in_valid in the REPORT cycle starts the next maze without a gap
        if (in_valid) begin
          state_d    = S_LOAD;
          maze_d[0]  = maze;
          row_cnt_d  = 3'd1;
`ifdef RIM_CHK_REVISIT_EN
          visited_d  = '0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          maze_d[row_cnt_q] = maze;
          if (row_cnt_q == 3'd7) begin
            state_d = S_WAIT;
            idle_d  = '0;
            k_d     = '0;
            err_d   = E_NONE;
          end else begin
            row_cnt_d = row_cnt_q + 3'd1;
          end
        end else begin
          state_d = S_IDLE;
          maze_d  = '0;
        end
      end
      S_WAIT, S_PATH: begin
        if (out_valid) begin
          state_d  = S_PATH;
          if (err_q == E_NONE && code != E_NONE) err_d = code;
          k_d      = (k_q == 5'd31) ? k_q : k_q + 5'd1;
          prev_r_d = out_row;
          prev_c_d = out_col;
`ifdef RIM_CHK_REVISIT_EN
          visited_d[{out_row, out_col}] = 1'b1;
`endif
        end else if (state_q == S_PATH) begin
          state_d  = S_REPORT;
          done_d   = 1'b1;
          pass_d   = (fin_err == E_NONE);
          errout_d = fin_err;
          steps_d  = k_q;
        end else if (idle_q + 10'd1 == TO_LIM) begin
          state_d  = S_REPORT;
          done_d   = 1'b1;
          pass_d   = 1'b0;
          errout_d = E_TMO;
          steps_d  = '0;
        end else begin
          idle_d = idle_q + 10'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      maze_q    <= '0;
      row_cnt_q <= '0;
      idle_q    <= '0;
      k_q       <= '0;
      err_q     <= '0;
      prev_r_q  <= '0;
      prev_c_q  <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      errout_q  <= '0;
      steps_q   <= '0;
`ifdef RIM_CHK_REVISIT_EN
      visited_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      maze_q    <= maze_d;
      row_cnt_q <= row_cnt_d;
      idle_q    <= idle_d;
      k_q       <= k_d;
      err_q     <= err_d;
      prev_r_q  <= prev_r_d;
      prev_c_q  <= prev_c_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      errout_q  <= errout_d;
      steps_q   <= steps_d;
`ifdef RIM_CHK_REVISIT_EN
      visited_q <= visited_d;
`endif
    end
  end

  assign chk_done  = done_q;
  assign chk_pass  = pass_q;
  assign chk_err   = errout_q;
  assign chk_steps = steps_q;

endmodule

// File: tb/tb_rim_path_checker.sv
// Directed bench for rim_path_checker: hand-computed verdicts for each maze/path scenario.
module tb_rim_path_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] maze = '0;
  logic       out_valid = 1'b0;
  logic [2:0] out_row = '0;
  logic [2:0] out_col = '0;
  logic       chk_done;
  logic       chk_pass;
  logic [2:0] chk_err;
  logic [4:0] chk_steps;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mz [8];
  logic [5:0] path [$];

`ifdef RIM_CHK_REVISIT_EN
  localparam logic [2:0] REV_ERR = 3'd7;
`else
  localparam logic [2:0] REV_ERR = 3'd4;
`endif

  rim_path_checker dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .maze(maze),
    .out_valid(out_valid), .out_row(out_row), .out_col(out_col),
    .chk_done(chk_done), .chk_pass(chk_pass), .chk_err(chk_err), .chk_steps(chk_steps)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic open_maze;
    for (int r = 0; r < 8; r++) mz[r] = 8'hFF;
  endtask

  task automatic load_maze;
    for (int r = 0; r < 8; r++) begin
      in_valid = 1'b1;
      maze = mz[r];
      tick();
    end
    in_valid = 1'b0;
    maze = '0;
  endtask

  task automatic pc(input int r, input int c);
    path.push_back({3'(r), 3'(c)});
  endtask

  task automatic add_run(input int r0, input int c0, input int r1, input int c1);
    int r = r0;
    int c = c0;
    pc(r, c);
    while (r != r1 || c != c1) begin
      if (r < r1) r++; else if (r > r1) r--;
      if (c < c1) c++; else if (c > c1) c--;
      pc(r, c);
    end
  endtask

  // Ends in the REPORT cycle so a following load_maze is back-to-back.
  task automatic send_path(input string tag);
    foreach (path[i]) begin
      out_valid = 1'b1;
      out_row = path[i][5:3];
      out_col = path[i][2:0];
      tick();
    end
    out_valid = 1'b0;
    chk({tag, "_nodone"}, 16'(chk_done), 16'd0);
    tick();
  endtask

  task automatic verdict(input string tag, input logic p, input logic [2:0] e, input logic [4:0] s);
    chk({tag, "_done"}, 16'(chk_done), 16'd1);
    chk({tag, "_pass"}, 16'(chk_pass), 16'(p));
    chk({tag, "_err"}, 16'(chk_err), 16'(e));
    chk({tag, "_steps"}, 16'(chk_steps), 16'(s));
  endtask

  initial begin
    int cnt;
    tick();
    chk("rst_done", 16'(chk_done), 16'd0);
    chk("rst_pass", 16'(chk_pass), 16'd0);
    chk("rst_err", 16'(chk_err), 16'd0);
    chk("rst_steps", 16'(chk_steps), 16'd0);
    rst_n = 1'b1;
    tick();

    // good path: right along row 0, down column 7
    open_maze();
    load_maze();
    path = {}; add_run(0, 0, 0, 7); add_run(1, 7, 7, 7);
    send_path("t1");
    verdict("t1", 1'b1, 3'd0, 5'd15);
    tick();
    chk("t1_pulse1", 16'(chk_done), 16'd0);
    chk("t1_hold", 16'(chk_steps), 16'd15);

    // bad start
    load_maze();
    path = {}; add_run(0, 1, 0, 7); add_run(1, 7, 7, 7);
    send_path("t2a");
    verdict("t2a", 1'b0, 3'd1, 5'd14);

    // diagonal (2,2)->(3,3), loaded back-to-back
    load_maze();
    path = {};
    pc(0, 0); pc(0, 1); pc(1, 1); pc(1, 2); pc(2, 2); pc(3, 3); pc(3, 4);
    pc(4, 4); pc(4, 5); pc(5, 5); pc(5, 6); pc(6, 6); pc(6, 7); pc(7, 7);
    send_path("t2b");
    verdict("t2b", 1'b0, 3'd3, 5'd14);

    // wall at row 3
    mz[3] = 8'h00;
    load_maze();
    path = {}; add_run(0, 0, 0, 7); add_run(1, 7, 7, 7);
    send_path("t3");
    verdict("t3", 1'b0, 3'd2, 5'd15);

    // row 0 column 0 walled, captured in the REPORT cycle
    open_maze();
    mz[0] = 8'h7F;
    load_maze();
    send_path("t3b");
    verdict("t3b", 1'b0, 3'd2, 5'd15);
    tick();

    // short path ending (7,6): length beats end
    open_maze();
    load_maze();
    path = {}; add_run(0, 0, 0, 6); add_run(1, 6, 7, 6);
    send_path("t4a");
    verdict("t4a", 1'b0, 3'd5, 5'd14);

    // right length, wrong end cell (5,7)
    load_maze();
    path = {}; pc(0, 0); pc(1, 0); pc(1, 1); add_run(0, 1, 0, 7); add_run(1, 7, 5, 7);
    send_path("t4b");
    verdict("t4b", 1'b0, 3'd4, 5'd15);

    // revisit of (1,1)
    load_maze();
    path = {}; add_run(0, 0, 0, 1); pc(1, 1); pc(1, 0); pc(1, 1); add_run(1, 2, 1, 7); add_run(2, 7, 5, 7);
    send_path("rev");
    verdict("rev", 1'b0, REV_ERR, 5'd15);
    tick();

    // out_valid while idle is ignored
    for (int i = 0; i < 3; i++) begin
      out_valid = 1'b1; out_row = 3'(i); out_col = 3'd0;
      tick();
    end
    out_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (chk_done) cnt++;
    end
    chk("idle_ov_nodone", 16'(cnt), 16'd0);
    chk("idle_ov_hold", 16'(chk_err), 16'(REV_ERR));

    // timeout: done TIMEOUT cycles after last row
    load_maze();
    cnt = 0;
    while (!chk_done && cnt < 1100) begin
      tick();
      cnt++;
    end
    chk("tmo_cycles", 16'(cnt), 16'd1023);
    verdict("tmo", 1'b0, 3'd6, 5'd0);
    tick();

    // abort after 5 rows: no verdict
    for (int r = 0; r < 5; r++) begin
      in_valid = 1'b1; maze = 8'hA5;
      tick();
    end
    in_valid = 1'b0; maze = '0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (chk_done) cnt++;
    end
    chk("abort_nodone", 16'(cnt), 16'd0);
    chk("abort_hold", 16'(chk_err), 16'd6);

    // recovers cleanly after abort
    load_maze();
    path = {}; add_run(0, 0, 0, 7); add_run(1, 7, 7, 7);
    send_path("rec");
    verdict("rec", 1'b1, 3'd0, 5'd15);
    tick();

    // reset asserted while coordinate 7 is on the bus
    load_maze();
    for (int i = 0; i < 7; i++) begin
      out_valid = 1'b1; out_row = path[i][5:3]; out_col = path[i][2:0];
      tick();
    end
    out_row = path[7][5:3]; out_col = path[7][2:0];
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_done", 16'(chk_done), 16'd0);
    chk("mrst_pass", 16'(chk_pass), 16'd0);
    chk("mrst_err", 16'(chk_err), 16'd0);
    chk("mrst_steps", 16'(chk_steps), 16'd0);
    tick();
    out_valid = 1'b0;
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (chk_done) cnt++;
    end
    chk("mrst_nodone", 16'(cnt), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
